// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector.
// Watches a 1-bit stream qualified by rx_valid and matches a loaded pattern of
// 1..MAX_LEN bits, with overlapping or non-overlapping matches and a saturating
// match counter.
// Ports:
//   clk, rstn            clock (rising edge), async active-low reset
//   rx, rx_valid         serial bit and its qualifier
//   cfg_load             latch cfg_pattern/cfg_len/cfg_overlap (highest priority)
//   cfg_pattern          pattern; bit cfg_len-1 arrives first, bit 0 last
//   cfg_len              pattern length, legal range 1..MAX_LEN
//   cfg_overlap          1 = overlapping matches allowed
//   clr_cnt              synchronous clear of match_count
//   detected             one-cycle match pulse
//   armed                high while hunting (history holds >= len bits)
//   cfg_err              last cfg_load carried an illegal length
//   match_count          saturating number of detections
module seq_detector_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx,
  input  logic               rx_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               detected,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] hist, hist_nxt;
  logic [MAX_LEN-1:0] pat, pat_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [LEN_W-1:0]   fill_cnt, fill_nxt;
  logic               ovl, ovl_nxt;
  logic               det_nxt, armed_nxt, err_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic [MAX_LEN-1:0] shifted, mask;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_sat;
  logic               len_ok, sample, hit;

  // Match datapath: compare the low len bits of the post-shift history.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len);
    shifted  = {hist[MAX_LEN-2:0], rx};
    fill_inc = {1'b0, fill_cnt} + (LEN_W+1)'(1);
    fill_sat = (fill_inc > {1'b0, MAX_FILL}) ? MAX_FILL : fill_inc[LEN_W-1:0];
    len_ok   = (cfg_len != '0) && (cfg_len <= MAX_FILL);
    sample   = rx_valid && !cfg_load && (state != IDLE);
    hit      = sample && (fill_inc >= {1'b0, len}) && (((shifted ^ pat) & mask) == '0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    pat_nxt   = pat;
    len_nxt   = len;
    ovl_nxt   = ovl;
    fill_nxt  = fill_cnt;
    err_nxt   = cfg_err;
    det_nxt   = 1'b0;
    cnt_nxt   = match_count;

    if (cfg_load) begin
      if (len_ok) begin
        pat_nxt   = cfg_pattern;
        len_nxt   = cfg_len;
        ovl_nxt   = cfg_overlap;
        err_nxt   = 1'b0;
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end
    end else if (sample) begin
      hist_nxt = shifted;
      det_nxt  = hit;
      if (hit && !ovl) begin
        // Non-overlapping: restart the fill so old bits cannot be reused.
        fill_nxt  = '0;
        state_nxt = FILL;
      end else begin
        fill_nxt  = fill_sat;
        state_nxt = (fill_sat >= len) ? HUNT : FILL;
      end
    end

    if (clr_cnt)                            cnt_nxt = hit ? CNT_W'(1) : '0;
    else if (hit && (match_count != CNT_MAX)) cnt_nxt = match_count + CNT_W'(1);

    armed_nxt = (state_nxt == HUNT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      hist        <= '0;
      pat         <= '0;
      len         <= '0;
      ovl         <= 1'b0;
      fill_cnt    <= '0;
      detected    <= 1'b0;
      armed       <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_nxt;
      hist        <= hist_nxt;
      pat         <= pat_nxt;
      len         <= len_nxt;
      ovl         <= ovl_nxt;
      fill_cnt    <= fill_nxt;
      detected    <= det_nxt;
      armed       <= armed_nxt;
      cfg_err     <= err_nxt;
      match_count <= cnt_nxt;
    end
  end

endmodule
